// File: rtl/tx_packet_scheduler_pkg.sv
// Shared constants and helpers for the transmit packet scheduler.
package tx_packet_scheduler_pkg;

  // Bits per buffer byte; the converter emits two bits per clk.
  localparam int BYTE_LEN = 8;

  // Packet buffer depth in bytes (power of 2).
  localparam int PACKET_BUFFER_SIZE = 256;

  // 96 bit times of inter-frame gap at 2 bits per clk.
  localparam int TX_IFG_CYCLES = 48;

  // Ceiling log2; returns 0 for values <= 1.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/tx_packet_scheduler_desc_fifo.sv
// Descriptor queue: synchronous first-word-fall-through FIFO.
// Full/empty come from the registered count, so a pop never frees a slot
// for a push in the same cycle.
module tx_packet_scheduler_desc_fifo
  import tx_packet_scheduler_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int CW    = clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  localparam int PW = clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage write; contents are only meaningful where count says so.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is 2^PW.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/tx_packet_scheduler.sv
// Transmit packet scheduler: queues buffer descriptors and walks each packet
// through the read streamer and the dibit converter, then enforces the
// inter-frame gap. All outputs except desc_ready are registered; the FSM
// computes next-cycle output values and the register stage presents them.
//
// state    | meaning
// IDLE     | wait for a descriptor; pop it, zero length completes at once
// LOAD     | streamer start pulse plus first read-ready pulse
// PACE     | one read-ready pulse every PACE_CYCLES until all issued
// DRAIN    | wait until every requested byte has come back
// FLUSH    | end-of-packet pulse to the converter
// WAITDONE | wait for the converter to report its buffer flushed
// GAP      | inter-frame gap before the next descriptor
module tx_packet_scheduler
  import tx_packet_scheduler_pkg::*;
#(
  parameter int RAM_SIZE    = PACKET_BUFFER_SIZE,
  parameter int QUEUE_DEPTH = 4,
  parameter int IFG_CYCLES  = TX_IFG_CYCLES,
  parameter int PACE_CYCLES = BYTE_LEN / 2,
  localparam int AW = clog2(RAM_SIZE),
  localparam int CW = clog2(QUEUE_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          desc_valid,
  input  logic [AW-1:0] desc_start,
  input  logic [AW-1:0] desc_end,
  output logic          desc_ready,
  output logic [CW-1:0] queue_count,
  output logic          sfm_start,
  output logic [AW-1:0] sfm_read_start,
  output logic [AW-1:0] sfm_read_end,
  output logic          sfm_ready,
  input  logic          byte_clk,
  output logic          done_req,
  input  logic          dibit_done,
  output logic          busy,
  output logic          pkt_sent
);

  // A pace of 0 or 1 both mean back-to-back pulses.
  localparam int PACE_M1 = (PACE_CYCLES > 1) ? PACE_CYCLES - 1 : 0;
  localparam int PCW     = clog2(PACE_M1 + 2);
  localparam int GCW     = clog2(IFG_CYCLES + 2);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    PACE     = 3'd2,
    DRAIN    = 3'd3,
    FLUSH    = 3'd4,
    WAITDONE = 3'd5,
    GAP      = 3'd6
  } state_e;

  state_e state;
  state_e state_next;

  logic [2*AW-1:0] head;
  logic [AW-1:0]   head_start;
  logic [AW-1:0]   head_end;
  logic [AW-1:0]   head_len;
  logic            fifo_full;
  logic            fifo_empty;
  logic            fifo_pop;

  logic [AW-1:0]   len_r;
  logic [AW-1:0]   issued;
  logic [AW-1:0]   received;
  logic [PCW-1:0]  pace_cnt;
  logic [GCW-1:0]  gap_cnt;

  logic            load_desc;
  logic            gap_load;
  logic            start_d;
  logic            ready_d;
  logic            done_d;
  logic            sent_d;
  logic            in_packet;

  tx_packet_scheduler_desc_fifo #(
    .WIDTH (2 * AW),
    .DEPTH (QUEUE_DEPTH),
    .CW    (CW)
  ) u_desc_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (desc_valid),
    .push_data ({desc_start, desc_end}),
    .pop       (fifo_pop),
    .pop_data  (head),
    .count     (queue_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign desc_ready = !fifo_full;
  assign head_start = head[2*AW-1:AW];
  assign head_end   = head[AW-1:0];
  // Modular subtraction handles descriptors that wrap the buffer end.
  assign head_len   = head_end - head_start;
  assign in_packet  = (state == LOAD) || (state == PACE) || (state == DRAIN);

  // Next-state decode and next-cycle output values.
  always_comb begin
    state_next = state;
    fifo_pop   = 1'b0;
    load_desc  = 1'b0;
    gap_load   = 1'b0;
    start_d    = 1'b0;
    ready_d    = 1'b0;
    done_d     = 1'b0;
    sent_d     = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (head_len == '0) begin
            sent_d = 1'b1;
          end else begin
            load_desc  = 1'b1;
            start_d    = 1'b1;
            ready_d    = 1'b1;
            state_next = LOAD;
          end
        end
      end
      LOAD: begin
        if (len_r == AW'(1)) begin
          state_next = DRAIN;
        end else begin
          state_next = PACE;
          if (pace_cnt == '0) begin
            ready_d = 1'b1;
          end
        end
      end
      PACE: begin
        if (issued == len_r) begin
          state_next = DRAIN;
        end else if (pace_cnt == '0) begin
          ready_d = 1'b1;
        end
      end
      DRAIN: begin
        if (received == len_r) begin
          done_d     = 1'b1;
          state_next = FLUSH;
        end
      end
      FLUSH: begin
        state_next = WAITDONE;
      end
      WAITDONE: begin
        if (dibit_done) begin
          sent_d = 1'b1;
          if (IFG_CYCLES == 0) begin
            state_next = IDLE;
          end else begin
            gap_load   = 1'b1;
            state_next = GAP;
          end
        end
      end
      GAP: begin
        if (gap_cnt == '0) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      sfm_start <= 1'b0;
      sfm_ready <= 1'b0;
      done_req  <= 1'b0;
      pkt_sent  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_next;
      sfm_start <= start_d;
      sfm_ready <= ready_d;
      done_req  <= done_d;
      pkt_sent  <= sent_d;
      busy      <= (state_next != IDLE);
    end
  end

  // Descriptor latch plus issue/receive/pace bookkeeping for the packet.
  always_ff @(posedge clk) begin
    if (reset) begin
      len_r          <= '0;
      issued         <= '0;
      received       <= '0;
      pace_cnt       <= '0;
      sfm_read_start <= '0;
      sfm_read_end   <= '0;
    end else if (load_desc) begin
      len_r          <= head_len;
      issued         <= AW'(1);
      received       <= '0;
      pace_cnt       <= PCW'(PACE_M1);
      sfm_read_start <= head_start;
      sfm_read_end   <= head_end;
    end else begin
      if (ready_d) begin
        issued   <= issued + AW'(1);
        pace_cnt <= PCW'(PACE_M1);
      end else if (((state == LOAD) || (state == PACE)) && (pace_cnt != '0)) begin
        pace_cnt <= pace_cnt - PCW'(1);
      end
      // Saturate so stray byte_clk pulses cannot overshoot the length.
      if (byte_clk && in_packet && (received != len_r)) begin
        received <= received + AW'(1);
      end
    end
  end

  // Inter-frame gap down-counter; loaded when the converter reports done.
  always_ff @(posedge clk) begin
    if (reset) begin
      gap_cnt <= '0;
    end else if (gap_load) begin
      gap_cnt <= GCW'(IFG_CYCLES);
    end else if ((state == GAP) && (gap_cnt != '0)) begin
      gap_cnt <= gap_cnt - GCW'(1);
    end
  end

endmodule

// File: tb/tb_tx_packet_scheduler.sv
// Directed bench for tx_packet_scheduler with default parameters
// (256-byte buffer, 4-deep queue, 48-cycle gap, 4-cycle pace).
module tb_tx_packet_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       desc_valid;
  logic [7:0] desc_start;
  logic [7:0] desc_end;
  logic       desc_ready;
  logic [2:0] queue_count;
  logic       sfm_start;
  logic [7:0] sfm_read_start;
  logic [7:0] sfm_read_end;
  logic       sfm_ready;
  logic       byte_clk;
  logic       done_req;
  logic       dibit_done;
  logic       busy;
  logic       pkt_sent;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Streamer model: byte_clk follows sfm_ready after lat cycles, plus
  // an optional injected stray pulse.
  logic [7:0] rd_pipe = '0;
  int         lat     = 1;
  logic       spur    = 1'b0;

  int start_t[$];
  int start_a[$];
  int end_a[$];
  int rdy_t[$];
  int done_t[$];
  int sent_t[$];

  tx_packet_scheduler dut (
    .clk            (clk),
    .reset          (reset),
    .desc_valid     (desc_valid),
    .desc_start     (desc_start),
    .desc_end       (desc_end),
    .desc_ready     (desc_ready),
    .queue_count    (queue_count),
    .sfm_start      (sfm_start),
    .sfm_read_start (sfm_read_start),
    .sfm_read_end   (sfm_read_end),
    .sfm_ready      (sfm_ready),
    .byte_clk       (byte_clk),
    .done_req       (done_req),
    .dibit_done     (dibit_done),
    .busy           (busy),
    .pkt_sent       (pkt_sent)
  );

  always #5 clk = ~clk;

  // Cycle counter.
  always @(posedge clk) cyc <= cyc + 1;

  // Streamer read latency pipe.
  always @(posedge clk) rd_pipe <= {rd_pipe[6:0], sfm_ready};
  assign byte_clk = rd_pipe[3'(lat - 1)] | spur;

  // Time-stamp output pulses mid-cycle.
  always @(negedge clk) begin
    if (sfm_start) begin
      start_t.push_back(cyc);
      start_a.push_back(int'(sfm_read_start));
      end_a.push_back(int'(sfm_read_end));
    end
    if (sfm_ready) rdy_t.push_back(cyc);
    if (done_req) done_t.push_back(cyc);
    if (pkt_sent) sent_t.push_back(cyc);
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int s, input int e);
    desc_valid = 1'b1;
    desc_start = 8'(s);
    desc_end   = 8'(e);
    step();
    desc_valid = 1'b0;
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_desc_ready"}, int'(desc_ready), 1);
    chk({pfx, "_queue_count"}, int'(queue_count), 0);
    chk({pfx, "_sfm_start"}, int'(sfm_start), 0);
    chk({pfx, "_sfm_ready"}, int'(sfm_ready), 0);
    chk({pfx, "_read_start"}, int'(sfm_read_start), 0);
    chk({pfx, "_read_end"}, int'(sfm_read_end), 0);
    chk({pfx, "_done_req"}, int'(done_req), 0);
    chk({pfx, "_busy"}, int'(busy), 0);
    chk({pfx, "_pkt_sent"}, int'(pkt_sent), 0);
  endtask

  // Wait for done_req, answer with dibit_done two cycles later,
  // and expect pkt_sent on the following cycle.
  task automatic finish_pkt(input string tag, output int v);
    int found = 0;
    for (int i = 0; i < 300; i++) begin
      if (done_req) begin
        found = 1;
        break;
      end
      step();
    end
    chk({tag, "_done_req_seen"}, found, 1);
    step();
    step();
    dibit_done = 1'b1;
    v = cyc;
    step();
    dibit_done = 1'b0;
    chk({tag, "_pkt_sent_next"}, int'(pkt_sent), 1);
  endtask

  task automatic wait_idle(input string tag);
    int found = 0;
    for (int i = 0; i < 300; i++) begin
      if (!busy) begin
        found = 1;
        break;
      end
      step();
    end
    chk({tag, "_idle_reached"}, found, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int p, v, s0, n0, d0, e0;
    reset      = 1'b1;
    desc_valid = 1'b0;
    desc_start = '0;
    desc_end   = '0;
    dibit_done = 1'b0;
    repeat (3) step();
    chk_reset_vals("rst");
    reset = 1'b0;
    step();

    // Single packet 10..14.
    s0 = start_t.size(); n0 = rdy_t.size(); d0 = done_t.size(); e0 = sent_t.size();
    p = cyc;
    push(10, 14);
    finish_pkt("t1", v);
    step();
    chk("t1_busy_in_gap", int'(busy), 1);
    chk("t1_start_count", start_t.size() - s0, 1);
    chk("t1_start_time", start_t[s0], p + 2);
    chk("t1_read_start", start_a[s0], 10);
    chk("t1_read_end", end_a[s0], 14);
    chk("t1_ready_count", rdy_t.size() - n0, 4);
    for (int k = 0; k < 4; k++) chk("t1_ready_time", rdy_t[n0 + k], p + 2 + 4 * k);
    chk("t1_done_window", int'(done_t[d0] >= p + 16 && done_t[d0] <= p + 17), 1);
    chk("t1_sent_time", sent_t[e0], v + 1);

    // Wrap-around 254..2, queued during the gap.
    s0 = start_t.size(); n0 = rdy_t.size();
    push(254, 2);
    finish_pkt("t2", v);
    step();
    chk("t2_start_count", start_t.size() - s0, 1);
    chk("t2_gap_after_t1", int'(start_t[s0] - sent_t[e0] >= 50), 1);
    chk("t2_read_start", start_a[s0], 254);
    chk("t2_read_end", end_a[s0], 2);
    chk("t2_ready_count", rdy_t.size() - n0, 4);
    for (int k = 1; k < 4; k++) chk("t2_ready_spacing", rdy_t[n0 + k] - rdy_t[n0], 4 * k);

    // Fill queue during the gap, fifth push must be refused.
    s0 = start_t.size(); e0 = sent_t.size();
    push(20, 22);
    push(30, 32);
    push(40, 42);
    push(50, 52);
    chk("t3_count_full", int'(queue_count), 4);
    chk("t3_ready_low", int'(desc_ready), 0);
    push(60, 62);
    chk("t3_count_after_5th", int'(queue_count), 4);
    chk("t3_ready_still_low", int'(desc_ready), 0);
    for (int k = 0; k < 4; k++) finish_pkt("t3", v);
    step();
    wait_idle("t3");
    repeat (5) step();
    chk("t3_start_count", start_t.size() - s0, 4);
    for (int k = 0; k < 4; k++) chk("t3_fifo_order", start_a[s0 + k], 20 + 10 * k);
    for (int k = 0; k < 3; k++) chk("t3_gap", int'(start_t[s0 + k + 1] - sent_t[e0 + k] >= 50), 1);
    chk("t3_queue_empty", int'(queue_count), 0);

    // Zero-length descriptor then a 1-byte packet.
    s0 = start_t.size(); n0 = rdy_t.size(); e0 = sent_t.size();
    p = cyc;
    push(7, 7);
    push(8, 9);
    chk("t4_zero_sent", int'(pkt_sent), 1);
    chk("t4_zero_not_busy", int'(busy), 0);
    chk("t4_zero_no_start", int'(sfm_start), 0);
    step();
    chk("t4_one_start", int'(sfm_start), 1);
    chk("t4_one_addr", int'(sfm_read_start), 8);
    chk("t4_one_busy", int'(busy), 1);
    finish_pkt("t4", v);
    step();
    chk("t4_start_count", start_t.size() - s0, 1);
    chk("t4_ready_count", rdy_t.size() - n0, 1);
    chk("t4_zero_sent_time", sent_t[e0], p + 2);
    chk("t4_one_sent_time", sent_t[e0 + 1], v + 1);

    // Read latency 3 with one stray byte_clk after the last byte.
    wait_idle("t5");
    lat = 3;
    n0 = rdy_t.size(); d0 = done_t.size(); e0 = sent_t.size();
    p = cyc;
    push(100, 104);
    repeat (17) step();
    spur = 1'b1;
    step();
    spur = 1'b0;
    finish_pkt("t5", v);
    step();
    chk("t5_ready_count", rdy_t.size() - n0, 4);
    chk("t5_done_window", int'(done_t[d0] >= p + 18 && done_t[d0] <= p + 19), 1);
    chk("t5_sent_time", sent_t[e0], v + 1);
    wait_idle("t5b");
    chk("t5_done_count", done_t.size() - d0, 1);
    lat = 1;

    // Reset while pacing with two descriptors still queued.
    repeat (5) step();
    s0 = start_t.size(); d0 = done_t.size(); e0 = sent_t.size();
    push(110, 118);
    push(120, 121);
    push(130, 131);
    step();
    step();
    chk("t6_queued_before_reset", int'(queue_count), 2);
    chk("t6_busy_before_reset", int'(busy), 1);
    reset = 1'b1;
    step();
    chk_reset_vals("t6");
    reset = 1'b0;
    repeat (80) step();
    chk("t6_start_count", start_t.size() - s0, 1);
    chk("t6_no_done", done_t.size() - d0, 0);
    chk("t6_no_sent", sent_t.size() - e0, 0);
    chk("t6_queue_flushed", int'(queue_count), 0);
    chk("t6_idle", int'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tx_packet_scheduler.md
# tx_packet_scheduler

Transmit-side controller that queues packet descriptors (start/end offsets in the packet buffer) and sequences each packet through the read streamer and the byte-to-dibit converter. It issues the streamer start pulse and one read-ready pulse per byte at the converter's maximum byte rate, then signals end of packet. It waits for the converter to flush and enforces an inter-frame gap before the next packet. It sits between the packet-assembly logic and the RMII transmit path.

## Interface
- RAM_SIZE, default PACKET_BUFFER_SIZE: packet buffer depth in bytes; must be a power of 2.
- QUEUE_DEPTH, default 4: descriptor FIFO depth; must be a power of 2.
- IFG_CYCLES, default 48: idle clk cycles between packets (96 bit times at 2 bits/cycle).
- PACE_CYCLES, default BYTE_LEN/2: minimum spacing between read-ready pulses.

Reset/clock: reset reset, synchronous, active-high; clock clk.
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- desc_valid  in  1  enqueue request
- desc_start  in  clog2(RAM_SIZE)  first byte address
- desc_end  in  clog2(RAM_SIZE)  one past last byte (wraps)
- desc_ready  out  1  queue not full
- queue_count  out  clog2(QUEUE_DEPTH)+1  descriptors queued
- sfm_start  out  1  start pulse to streamer
- sfm_read_start  out  clog2(RAM_SIZE)  streamer start address
- sfm_read_end  out  clog2(RAM_SIZE)  streamer end address
- sfm_ready  out  1  per-byte read-ready pulse to streamer
- byte_clk  in  1  streamer byte-valid (one pulse per delivered byte)
- done_req  out  1  end-of-packet pulse to converter done_in
- dibit_done  in  1  converter done_out (buffer flushed)
- busy  out  1  not in IDLE
- pkt_sent  out  1  one-cycle completion pulse

## Operation
- **Enqueue:** accepted when desc_valid && desc_ready. desc_ready = (queue_count != QUEUE_DEPTH), computed combinationally from count; a pop in the same cycle does not free a slot for that cycle's push.
- **Length:** len = (desc_end - desc_start) mod RAM_SIZE, width clog2(RAM_SIZE). Wrap-around is legal. start == end means zero length.
- **FSM states:** IDLE, LOAD, PACE, DRAIN, FLUSH, WAITDONE, GAP.
  - IDLE: if queue non-empty, pop and latch start/end/len. If len == 0, pulse pkt_sent and stay in IDLE; otherwise go to LOAD.
  - LOAD: sfm_start = 1 and sfm_ready = 1 (first pulse); issued = 1; go to PACE, or to DRAIN if len == 1.
  - PACE: sfm_ready pulses once every PACE_CYCLES cycles until issued == len, then go to DRAIN.
  - DRAIN: wait until received == len. received counts byte_clk from LOAD onward, in any state from LOAD to DRAIN. Extra byte_clk pulses are ignored (saturate at len).
  - FLUSH: done_req = 1 for one cycle; go to WAITDONE.
  - WAITDONE: on dibit_done, pulse pkt_sent; go to GAP, or to IDLE if IFG_CYCLES == 0.
  - GAP: count IFG_CYCLES cycles, then go to IDLE.
- sfm_read_start/sfm_read_end hold their latched values until the next LOAD.
- byte_clk and dibit_done are ignored in IDLE and GAP.
- Reset mid-packet: FSM returns to IDLE, queue is flushed, counters clear, and no done_req or pkt_sent is emitted. Downstream blocks are reset by the same signal.

## Timing
- Reset values: desc_ready 1, queue_count 0, sfm_start 0, sfm_ready 0, sfm_read_start 0, sfm_read_end 0, done_req 0, busy 0, pkt_sent 0.
- All outputs are registered except desc_ready.
- Packet popped in IDLE at cycle T:
  - LOAD (sfm_start, first sfm_ready) at T+1.
  - k-th sfm_ready at T+1+PACE_CYCLES*(k-1).
- Last byte_clk at cycle U: done_req at U+1 or later (after PACE completes).
- dibit_done at cycle V: pkt_sent at V+1. Next LOAD no earlier than V+1+IFG_CYCLES+2.
- busy goes high at T+1 and low on the cycle IDLE is re-entered.
- Zero-length descriptor: pkt_sent at T+1, no sfm_start, no gap.
- Push into an empty queue while IDLE: pop occurs the following cycle.

## Structure
- params.vh: BYTE_LEN, PACKET_BUFFER_SIZE, clog2(), and a new TX_IFG_CYCLES constant used as the IFG_CYCLES default.
- FSM state encodings are localparams in the module.
- One sub-module, desc_fifo: a synchronous FIFO of width 2*clog2(RAM_SIZE) with push/pop/count/full/empty. Read data is valid in the same cycle as non-empty (first-word fall-through).

## Test plan
- Single packet (start 10, end 14) with IFG_CYCLES 48 -> sfm_start once with addresses 10/14; 4 sfm_ready pulses spaced 4 cycles; done_req after 4th byte_clk; pkt_sent one cycle after dibit_done; next LOAD ≥ 50 cycles later.
- Wrap-around (start RAM_SIZE-2, end 2) -> exactly 4 sfm_ready pulses, addresses passed unchanged.
- Fill queue with 4 descriptors plus a 5th push -> desc_ready 0 and 5th rejected (queue_count stays 4); all 4 packets sent in FIFO order with gaps between them.
- Zero-length descriptor (start == end == 7) followed by 1-byte packet -> pkt_sent at T+1 with no sfm_start; 1-byte packet then goes LOAD -> DRAIN -> FLUSH.
- Delayed byte_clk (RAM latency 3 cycles, one extra spurious pulse) -> done_req only after 4th byte; extra pulse ignored.
- Reset asserted in PACE with 2 descriptors queued -> all outputs return to reset values next cycle, queue_count 0, no pkt_sent or done_req.
